// File: rtl/calc_pkg.sv
// Shared calculator definitions: default operand width (common with the
// shift-add multiplier) and the one-hot divider state encoding.
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    // One-hot so each state decodes from a single flop.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_SHIFT = 4'b0010,
        S_TEST  = 4'b0100,
        S_DONE  = 4'b1000
    } div_state_t;

endpackage

// File: rtl/div_control.sv
// Divider control: one-hot FSM plus iteration counter. Issues datapath
// strobes (Load/Shift/Sub/Halt) and the Moore status outputs Busy/Done.
import calc_pkg::*;

module div_control #(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Go,
    input  logic Ge,
    input  logic ZeroDiv,
    output logic Load,
    output logic Shift,
    output logic Sub,
    output logic Halt,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;

    // Next-state, counter and strobe decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d = state_q;
        count_d = count_q;
        Load    = 1'b0;
        Shift   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (Go) begin
                    Load    = 1'b1;
                    count_d = CW'(WIDTH);
                    state_d = ZeroDiv ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                Shift   = 1'b1;
                state_d = S_TEST;
            end
            S_TEST: begin
                Sub     = Ge;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    Halt    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers; reset returns to IDLE.
    always_ff @(posedge Clock or negedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign Busy = (state_q == S_SHIFT) || (state_q == S_TEST);
    assign Done = (state_q == S_DONE);

endmodule

// File: rtl/div_unit.sv
// Sequential restoring unsigned divider (shift-subtract), the '/' companion
// of the calculator's shift-add multiplier. Datapath lives here; sequencing
// is in div_control. Optional feature macro: DIV_ZERO_CHECK_EN (early
// divide-by-zero exit with DivErr).
import calc_pkg::*;

module div_unit #(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Go,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivErr
);

    logic [WIDTH:0]   a_q, a_d;      // partial remainder, one guard bit
    logic [WIDTH-1:0] q_q, q_d;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] m_q, m_d;      // captured divisor
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             load, shift, sub, halt, ge, zero_div;

    assign ge = (a_q >= {1'b0, m_q});

`ifdef DIV_ZERO_CHECK_EN
    assign zero_div = (Divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    div_control #(.WIDTH(WIDTH)) u_control (
        .Clock   (Clock),
        .Reset   (Reset),
        .Go      (Go),
        .Ge      (ge),
        .ZeroDiv (zero_div),
        .Load    (load),
        .Shift   (shift),
        .Sub     (sub),
        .Halt    (halt),
        .Busy    (Busy),
        .Done    (Done)
    );

    // Datapath next-state: capture, shift, conditional subtract, result latch.
    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        m_d   = m_q;
        quo_d = quo_q;
        rem_d = rem_q;
        if (load) begin
            a_d = '0;
            q_d = Dividend;
            m_d = Divisor;
            if (zero_div) begin
                quo_d = '0;
                rem_d = '0;
            end
        end
        // A < M before every shift, so the guard bit is always 0 and can be dropped.
        if (shift) {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
        if (sub) begin
            a_d    = a_q - {1'b0, m_q};
            q_d[0] = 1'b1;
        end
        // Results publish only on the final TEST step, including that step's bit.
        if (halt) begin
            quo_d = q_d;
            rem_d = a_d[WIDTH-1:0];
        end
    end

    // Datapath registers; reset discards any operation in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            m_q   <= m_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;

`ifdef DIV_ZERO_CHECK_EN
    logic div_err_q;

    // Error flag follows each accepted Go: set for zero divisor, else cleared.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)    div_err_q <= 1'b0;
        else if (load) div_err_q <= zero_div;
    end

    assign DivErr = div_err_q;
`else
    assign DivErr = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operands, compared against an arithmetic reference (/ and %).
module tb_div_unit;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 60;

    logic             Clock;
    logic             Reset;
    logic             Go;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivErr;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Go        (Go),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivErr    (DivErr)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor per build option.
    task automatic model(input int a, input int b,
                         output int eq, output int er, output int eerr,
                         output int elat, output int ebusy);
`ifdef DIV_ZERO_CHECK_EN
        if (b == 0) begin
            eq = 0; er = 0; eerr = 1; elat = 1; ebusy = 0;
            return;
        end
`endif
        eerr  = 0;
        elat  = 2 * WIDTH + 1;
        ebusy = 2 * WIDTH;
        if (b == 0) begin
            eq = (1 << WIDTH) - 1;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
    endtask

    // One operation from a negedge; optional stray Go pulse after edge pulse_at.
    task automatic run_div(input int a, input int b, input int pulse_at);
        int eq, er, eerr, elat, ebusy;
        int edges, busy_cnt;
        string t;
        model(a, b, eq, er, eerr, elat, ebusy);
        t = $sformatf("%0d/%0d", a, b);
        Go       = 1'b1;
        Dividend = WIDTH'(a);
        Divisor  = WIDTH'(b);
        @(negedge Clock);
        edges    = 1;
        busy_cnt = 0;
        Go       = 1'b0;
        check({t, " done_after_go"}, 32'(Done), 32'(elat == 1));
        while (!Done && edges < TIMEOUT) begin
            if (Busy) busy_cnt++;
            Go = (edges == pulse_at);
            Dividend = WIDTH'($urandom);
            Divisor  = WIDTH'($urandom);
            @(negedge Clock);
            edges++;
        end
        Go = 1'b0;
        check({t, " done"},      32'(Done),      32'd1);
        check({t, " latency"},   edges,          elat);
        check({t, " busy_cyc"},  busy_cnt,       ebusy);
        check({t, " busy_end"},  32'(Busy),      32'd0);
        check({t, " quotient"},  32'(Quotient),  eq);
        check({t, " remainder"}, 32'(Remainder), er);
        check({t, " diverr"},    32'(DivErr),    eerr);
        @(negedge Clock);
        check({t, " done_hold"}, 32'(Done),      32'd1);
        check({t, " quo_hold"},  32'(Quotient),  eq);
    endtask

    initial begin
        int a, b;
        Reset    = 1'b0;
        Go       = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(negedge Clock);
        check("reset quotient",  32'(Quotient),  32'd0);
        check("reset remainder", 32'(Remainder), 32'd0);
        check("reset busy",      32'(Busy),      32'd0);
        check("reset done",      32'(Done),      32'd0);
        check("reset diverr",    32'(DivErr),    32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // Directed cases, including a stray Go mid-operation.
        run_div(100, 7, 0);
        run_div(255, 1, 0);
        run_div(5, 9, 0);
        run_div(8, 8, 0);
        run_div(37, 0, 0);
        run_div(100, 7, 5);
        run_div(0, 13, 0);
        run_div(255, 255, 0);

        // Reset in the middle of an operation aborts it.
        Go = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
        @(negedge Clock);
        Go = 1'b0;
        repeat (7) @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("midreset quotient",  32'(Quotient),  32'd0);
        check("midreset remainder", 32'(Remainder), 32'd0);
        check("midreset busy",      32'(Busy),      32'd0);
        check("midreset done",      32'(Done),      32'd0);
        check("midreset diverr",    32'(DivErr),    32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        run_div(50, 6, 0);
        // Immediate restart from DONE.
        run_div(200, 3, 0);

        // Random operands, roughly one in eight with a zero divisor.
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, (1 << WIDTH) - 1));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << WIDTH) - 1));
            run_div(a, b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
